// File: rtl/sr_latch_driver_if.sv
// Request and feedback bundle between control logic, the SR latch driver and the SR gate.
// The slave side belongs to the driver; master is the surrounding environment.
interface sr_latch_driver_if;
  logic req_valid;
  logic req_level;
  logic req_ready;
  logic s_out;
  logic r_out;
  logic q_fb;
  logic qbar_fb;
  logic done;
  logic err;
  logic level;
  logic level_valid;

  modport master (
    output req_valid, req_level, q_fb, qbar_fb,
    input  req_ready, s_out, r_out, done, err, level, level_valid
  );

  modport slave (
    input  req_valid, req_level, q_fb, qbar_fb,
    output req_ready, s_out, r_out, done, err, level, level_valid
  );
endinterface

// File: rtl/sr_latch_driver.sv
// Drives a fixed-width set or reset pulse into a latching SR gate and confirms the
// resulting state through synchronised Q/Qbar feedback, with a bounded timeout.
module sr_latch_driver #(
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int SYNC_STAGES    = 2
) (
  input logic          clk,
  input logic          reset,
  sr_latch_driver_if.slave bus
);
  localparam int CNT_MAX = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PULSE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]             state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   lvl_r;
  logic                   req_ready_r;
  logic                   s_out_r;
  logic                   r_out_r;
  logic                   done_r;
  logic                   err_r;
  logic                   level_r;
  logic                   level_valid_r;
  logic [SYNC_STAGES-1:0] q_sync_r;
  logic [SYNC_STAGES-1:0] qbar_sync_r;
  logic                   q_s;
  logic                   qbar_s;
  logic                   match_s;
  logic                   accept_s;
  logic                   accept_match_s;

  // Feedback is only trusted when Q and Qbar disagree, so a floating gate never confirms.
  always_comb begin
    q_s            = q_sync_r[SYNC_STAGES-1];
    qbar_s         = qbar_sync_r[SYNC_STAGES-1];
    match_s        = (q_s != qbar_s) && (q_s == lvl_r);
    accept_match_s = (q_s != qbar_s) && (q_s == bus.req_level);
    accept_s       = bus.req_valid && req_ready_r && (state_r == IDLE);
  end

  // Synchroniser chains for the asynchronous gate feedback.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_sync_r    <= '0;
      qbar_sync_r <= '0;
    end else begin
      q_sync_r    <= {q_sync_r[SYNC_STAGES-2:0], bus.q_fb};
      qbar_sync_r <= {qbar_sync_r[SYNC_STAGES-2:0], bus.qbar_fb};
    end
  end

  // Request acceptance, pulse generation and confirmation sequencing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      lvl_r         <= 1'b0;
      req_ready_r   <= 1'b0;
      s_out_r       <= 1'b0;
      r_out_r       <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
      level_r       <= 1'b0;
      level_valid_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            lvl_r       <= bus.req_level;
            req_ready_r <= 1'b0;
            cnt_r       <= '0;
            if (accept_match_s) begin
              done_r <= 1'b1;
            end else begin
              state_r <= PULSE;
              s_out_r <= bus.req_level;
              r_out_r <= ~bus.req_level;
            end
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        PULSE: begin
          if (cnt_r == PULSE_LAST) begin
            s_out_r <= 1'b0;
            r_out_r <= 1'b0;
            cnt_r   <= '0;
            state_r <= WAIT;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        WAIT: begin
          // A match on the last counted cycle still beats the timeout.
          if (match_s) begin
            done_r        <= 1'b1;
            level_r       <= lvl_r;
            level_valid_r <= 1'b1;
            req_ready_r   <= 1'b1;
            state_r       <= IDLE;
          end else if (cnt_r == TIMEOUT_LAST) begin
            err_r         <= 1'b1;
            level_valid_r <= 1'b0;
            req_ready_r   <= 1'b1;
            state_r       <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          s_out_r     <= 1'b0;
          r_out_r     <= 1'b0;
          req_ready_r <= 1'b0;
          cnt_r       <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_r;
  assign bus.s_out       = s_out_r;
  assign bus.r_out       = r_out_r;
  assign bus.done        = done_r;
  assign bus.err         = err_r;
  assign bus.level       = level_r;
  assign bus.level_valid = level_valid_r;

  sr_latch_driver_chk u_chk (
    .clk   (clk),
    .reset (reset),
    .s_out (s_out_r),
    .r_out (r_out_r),
    .done  (done_r),
    .err   (err_r)
  );
endmodule

module sr_latch_driver_chk (
  input logic clk,
  input logic reset,
  input logic s_out,
  input logic r_out,
  input logic done,
  input logic err
);
  a_no_forbidden: assert property (@(posedge clk) disable iff (reset) !(s_out && r_out));
  a_done_err_excl: assert property (@(posedge clk) disable iff (reset) !(done && err));
endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver with an SR gate model behind a one-cycle feedback delay.
module tb_sr_latch_driver;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic gate_q = 1'b0;
  logic stuck  = 1'b0;
  int   n_vec  = 0;
  int   n_bad  = 0;
  int   s_cnt, r_cnt, both_cnt, done_cnt, err_cnt, done_k, err_k, s_first, acc;
  logic seq [3];

  sr_latch_driver_if bus ();

  sr_latch_driver #(
    .PULSE_CYCLES   (4),
    .TIMEOUT_CYCLES (16),
    .SYNC_STAGES    (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // SR gate model; when stuck the gate is disconnected and both outputs read low.
  always @(posedge clk) begin
    if (!stuck) begin
      if (bus.s_out && !bus.r_out) gate_q <= 1'b1;
      else if (bus.r_out && !bus.s_out) gate_q <= 1'b0;
    end
    bus.q_fb    <= stuck ? 1'b0 : gate_q;
    bus.qbar_fb <= stuck ? 1'b0 : ~gate_q;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    s_cnt = 0; r_cnt = 0; both_cnt = 0; done_cnt = 0; err_cnt = 0;
    done_k = -1; err_k = -1; s_first = -1;
  endtask

  task automatic sample(input int k);
    if (bus.s_out) begin
      s_cnt++;
      if (s_first < 0) s_first = k;
    end
    if (bus.r_out) r_cnt++;
    if (bus.s_out && bus.r_out) both_cnt++;
    if (bus.done) begin
      done_cnt++;
      if (done_k < 0) done_k = k;
    end
    if (bus.err) begin
      err_cnt++;
      if (err_k < 0) err_k = k;
    end
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (!bus.req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_eq("ready_before_req", int'(bus.req_ready), 1);
  endtask

  // One-cycle request issued at a negedge; k counts negedges after the accepting edge.
  task automatic run_req(input logic lvl, input int ncyc);
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_level = lvl;
    clear_counts();
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      sample(k);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_level = 1'b0;
    seq[0] = 1'b1; seq[1] = 1'b0; seq[2] = 1'b1;

    repeat (3) @(negedge clk);
    check_eq("rst_s_out", int'(bus.s_out), 0);
    check_eq("rst_r_out", int'(bus.r_out), 0);
    check_eq("rst_done_err", int'({bus.done, bus.err}), 0);
    check_eq("rst_level", int'({bus.level, bus.level_valid}), 0);
    check_eq("rst_ready", int'(bus.req_ready), 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("ready_after_release", int'(bus.req_ready), 1);
    repeat (4) @(negedge clk);

    // Set from Q=0
    run_req(1'b1, 25);
    check_eq("set_s_cycles", s_cnt, 4);
    check_eq("set_s_first", s_first, 1);
    check_eq("set_r_cycles", r_cnt, 0);
    check_eq("set_done_cnt", done_cnt, 1);
    check_eq("set_done_k", done_k, 6);
    check_eq("set_err_cnt", err_cnt, 0);
    check_eq("set_level", int'(bus.level), 1);
    check_eq("set_level_valid", int'(bus.level_valid), 1);

    // Already set: confirmed on the accept cycle without pulsing
    run_req(1'b1, 8);
    check_eq("already_s_r", s_cnt + r_cnt, 0);
    check_eq("already_done_cnt", done_cnt, 1);
    check_eq("already_done_k", done_k, 1);

    // Reset the latch back to Q=0
    run_req(1'b0, 25);
    check_eq("clr_r_cycles", r_cnt, 4);
    check_eq("clr_s_cycles", s_cnt, 0);
    check_eq("clr_done_k", done_k, 6);
    check_eq("clr_level", int'(bus.level), 0);
    check_eq("clr_level_valid", int'(bus.level_valid), 1);

    // Timeout with feedback stuck at 0/0
    stuck = 1'b1;
    repeat (5) @(negedge clk);
    run_req(1'b1, 30);
    check_eq("to_s_cycles", s_cnt, 4);
    check_eq("to_err_cnt", err_cnt, 1);
    check_eq("to_err_k", err_k, 21);
    check_eq("to_done_cnt", done_cnt, 0);
    check_eq("to_level_valid", int'(bus.level_valid), 0);
    check_eq("to_level", int'(bus.level), 0);
    stuck = 1'b0;
    repeat (5) @(negedge clk);

    // Reset on the second s_out cycle
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_level = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_eq("mid_s_first", int'(bus.s_out), 1);
    @(negedge clk);
    check_eq("mid_s_second", int'(bus.s_out), 1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_s_dropped", int'({bus.s_out, bus.r_out}), 0);
    check_eq("mid_ready_in_reset", int'(bus.req_ready), 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("mid_ready_release", int'(bus.req_ready), 1);
    clear_counts();
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      sample(k);
    end
    check_eq("mid_no_done_err", done_cnt + err_cnt, 0);
    check_eq("mid_level_valid", int'(bus.level_valid), 0);

    // Back-to-back with req_valid held high: levels 1,0,1
    clear_counts();
    acc = 0;
    bus.req_valid = 1'b1;
    for (int k = 0; k < 150 && done_cnt < 3; k++) begin
      if (bus.req_ready && acc < 3) begin
        bus.req_level = seq[acc];
        acc++;
      end else if (acc == 3) begin
        bus.req_valid = 1'b0;
      end
      @(negedge clk);
      sample(k + 1);
    end
    bus.req_valid = 1'b0;
    check_eq("b2b_accepts", acc, 3);
    check_eq("b2b_done_cnt", done_cnt, 3);
    check_eq("b2b_err_cnt", err_cnt, 0);
    check_eq("b2b_overlap", both_cnt, 0);
    check_eq("b2b_s_cycles", s_cnt, 4);
    check_eq("b2b_r_cycles", r_cnt, 4);
    check_eq("b2b_level", int'(bus.level), 1);
    check_eq("b2b_level_valid", int'(bus.level_valid), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
